// File: rtl/fft_n4_pkg.sv
// rtl/fft_n4_pkg.sv - shared widths, point count and types for the 4-point DFT engine
package fft_n4_pkg;

  // Default widths: unsigned input samples and per-component output width
  localparam int W_IN_DEF  = 2;
  localparam int W_OUT_DEF = 4;

  // Number of time-domain points / frequency bins
  localparam int N_PTS = 4;

  // Sample and output-component types at the default widths
  typedef logic [W_IN_DEF-1:0]  sample_t;
  typedef logic [W_OUT_DEF-1:0] comp_t;

endpackage

// File: rtl/fft_n4_bfly.sv
// rtl/fft_n4_bfly.sv - radix-2 add/subtract butterfly, modulo 2^W
module fft_n4_bfly #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  // Two's complement wraparound gives the required modulo-2^W result for
  // both signed and unsigned interpretations of the operands.
  assign sum  = a + b;
  assign diff = a - b;

endmodule

// File: rtl/fft_n4.sv
// rtl/fft_n4.sv - pipelined radix-2 4-point DFT of unsigned real samples; FFT_N4_PIPE_EN adds a Stage A register (latency 2)
module fft_n4
  import fft_n4_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_IN-1:0]  x   [N_PTS],
  output logic             out_valid,
  output logic [W_OUT-1:0] Xr  [N_PTS],
  output logic [W_OUT-1:0] Xi  [N_PTS]
);

  // Inputs widened to the output width so every sum is exact before wrap
  logic [W_OUT-1:0] xe [N_PTS];

  // Stage A butterfly results (combinational) and the values fed to Stage B
  logic [W_OUT-1:0] a0_c, a1_c, b0_c, b1_c;
  logic [W_OUT-1:0] a0, a1, b0, b1;
  logic             valid_b;

  // Stage B results
  logic [W_OUT-1:0] x0_re, x2_re;
  logic [W_OUT-1:0] x1_re, x3_re;
  logic [W_OUT-1:0] x1_im, x3_im;

  // Twiddle product (-j) * (b1 + j*0): real/imag swapped, new imag negated
  logic [W_OUT-1:0] b1_im;
  logic [W_OUT-1:0] tw_re, tw_im;

  // Zero-extend the unsigned samples
  always_comb begin
    for (int i = 0; i < N_PTS; i++) begin
      xe[i] = '0;
      xe[i][W_IN-1:0] = x[i];
    end
  end

  // Stage A: even/odd pairs x0,x2 and x1,x3
  fft_n4_bfly #(.W(W_OUT)) u_bfly_a02 (
    .a    (xe[0]),
    .b    (xe[2]),
    .sum  (a0_c),
    .diff (a1_c)
  );

  fft_n4_bfly #(.W(W_OUT)) u_bfly_a13 (
    .a    (xe[1]),
    .b    (xe[3]),
    .sum  (b0_c),
    .diff (b1_c)
  );

`ifdef FFT_N4_PIPE_EN
  // Register Stage A results and their valid; cleared together on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a0      <= '0;
      a1      <= '0;
      b0      <= '0;
      b1      <= '0;
      valid_b <= 1'b0;
    end else begin
      valid_b <= in_valid;
      if (in_valid) begin
        a0 <= a0_c;
        a1 <= a1_c;
        b0 <= b0_c;
        b1 <= b1_c;
      end
    end
  end
`else
  // Stage A feeds Stage B directly in the single-cycle build
  always_comb begin
    a0      = a0_c;
    a1      = a1_c;
    b0      = b0_c;
    b1      = b1_c;
    valid_b = in_valid;
  end
`endif

  // b1 is purely real, so its imaginary part is zero
  assign b1_im = '0;
  assign tw_re = b1_im;
  assign tw_im = '0 - b1;

  // Stage B even bins: X0 = a0 + b0, X2 = a0 - b0
  fft_n4_bfly #(.W(W_OUT)) u_bfly_b_even (
    .a    (a0),
    .b    (b0),
    .sum  (x0_re),
    .diff (x2_re)
  );

  // Stage B odd bins, real part: a1 +/- re(-j*b1)
  fft_n4_bfly #(.W(W_OUT)) u_bfly_b_odd_re (
    .a    (a1),
    .b    (tw_re),
    .sum  (x1_re),
    .diff (x3_re)
  );

  // Stage B odd bins, imaginary part: im(a1) +/- im(-j*b1), with im(a1) = 0
  fft_n4_bfly #(.W(W_OUT)) u_bfly_b_odd_im (
    .a    ('0),
    .b    (tw_im),
    .sum  (x1_im),
    .diff (x3_im)
  );

  // Output register: load on valid, hold otherwise, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < N_PTS; i++) begin
        Xr[i] <= '0;
        Xi[i] <= '0;
      end
    end else begin
      out_valid <= valid_b;
      if (valid_b) begin
        Xr[0] <= x0_re;
        Xr[1] <= x1_re;
        Xr[2] <= x2_re;
        Xr[3] <= x3_re;
        Xi[0] <= '0;
        Xi[1] <= x1_im;
        Xi[2] <= '0;
        Xi[3] <= x3_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_n4.sv
// tb/tb_fft_n4.sv - self-checking bench for fft_n4 against a direct DFT reference; honours FFT_N4_PIPE_EN
module tb_fft_n4;
  import fft_n4_pkg::*;

`ifdef FFT_N4_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  sample_t    x  [N_PTS];
  logic       out_valid;
  comp_t      Xr [N_PTS];
  comp_t      Xi [N_PTS];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_seen = 1'b1;

  typedef struct {
    int          emit;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_data = '0;

  fft_n4 #(.W_IN(W_IN_DEF), .W_OUT(W_OUT_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .Xr        (Xr),
    .Xi        (Xi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Direct DFT: X[k] = sum x[n] * (cos(2*pi*k*n/4) - j*sin(2*pi*k*n/4)), wrapped to 4 bits
  function automatic logic [31:0] ref_dft(input int xs[4]);
    int cs[4] = '{1, 0, -1, 0};
    int sn[4] = '{0, 1, 0, -1};
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      int re = 0;
      int im = 0;
      for (int n = 0; n < 4; n++) begin
        re += xs[n] * cs[(k * n) % 4];
        im -= xs[n] * sn[(k * n) % 4];
      end
      r[k*4 +: 4]      = re[3:0];
      r[16 + k*4 +: 4] = im[3:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_out();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4]      = Xr[k];
      r[16 + k*4 +: 4] = Xi[k];
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_exp(input int r0, r1, r2, r3, i0, i1, i2, i3);
    int v[8] = '{r0, r1, r2, r3, i0, i1, i2, i3};
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = v[k][3:0];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Output observer, away from the active edge
  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_data", pack_out(), 32'd0);
      last_data = '0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.emit);
        check("bins", pack_out(), e.data);
        last_data = e.data;
      end
    end else begin
      check("hold", pack_out(), last_data);
    end
  end

  task automatic send(input bit v, input int a, b, c, d);
    int xs[4];
    @(posedge clk);
    #1;
    xs = '{a, b, c, d};
    rst      = 1'b0;
    in_valid = v;
    for (int i = 0; i < 4; i++) x[i] = xs[i][1:0];
    if (v) q.push_back('{emit: cyc + LAT, data: ref_dft(xs)});
  endtask

  // Reset held for n cycles; anything not yet emitted before the first reset edge is dropped
  task automatic reset_for(input int n);
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'($urandom);
    for (int i = 0; i < 4; i++) x[i] = 2'($urandom);
    foreach (q[i]) if (q[i].emit < cyc + 1) keep.push_back(q[i]);
    q = keep;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) x[i] = '0;
    repeat (3) @(posedge clk);

    // Directed sets with independently written expected bins
    send(1, 2, 1, 0, 1);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    check("plan_2101", ref_dft('{2, 1, 0, 1}), pack_exp(4, 2, 0, 2, 0, 0, 0, 0));
    send(1, 3, 3, 3, 3);
    check("plan_3333", ref_dft('{3, 3, 3, 3}), pack_exp(12, 0, 0, 0, 0, 0, 0, 0));
    send(1, 0, 3, 0, 0);
    check("plan_0300", ref_dft('{0, 3, 0, 0}), pack_exp(3, 0, -3, 0, 0, -3, 0, 3));
    send(0, 1, 2, 3, 0);
    send(1, 1, 0, 0, 0);
    send(1, 0, 1, 0, 0);
    send(1, 0, 0, 1, 0);
    check("plan_0100", ref_dft('{0, 1, 0, 0}), pack_exp(1, 0, -1, 0, 0, -1, 0, 1));
    check("plan_0010", ref_dft('{0, 0, 1, 0}), pack_exp(1, -1, 1, -1, 0, 0, 0, 0));
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);

    // Reset one cycle after launching a set, then a fresh set
    send(1, 2, 1, 0, 1);
    reset_for(2);
    send(1, 3, 2, 1, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);

    // Randomized traffic with idle gaps and occasional resets
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) reset_for($urandom_range(1, 3));
      else send(r > 5, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (LAT + 3) send(0, 0, 0, 0, 0);
    check("drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
